// File: rtl/pair_transmitter.sv
// rtl/pair_transmitter.sv - serialises an nBits word into 2-bit pairs, LSB pair first, one pair per divider tick
//
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous active-low reset
//   start     - send request, sampled only on a tick while idle
//   inData    - word captured when start is accepted
//   pairOut   - pair currently on the line
//   pairValid - pairOut carries a frame pair
//   busy      - frame in progress (sending or finishing)
//   ready     - last frame complete; held until the next accepted start
//   pairCount - number of 2'b11 pairs sent in the current/last frame
//   tick_out  - divider tick strobe

module pair_transmitter #(
    parameter int nBits       = 8,
    parameter int nOutputBits = 4,
    parameter int DIV_WIDTH   = 25
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [nBits-1:0]       inData,
    output logic [1:0]             pairOut,
    output logic                   pairValid,
    output logic                   busy,
    output logic                   ready,
    output logic [nOutputBits-1:0] pairCount,
    output logic                   tick_out
);

    localparam int NPAIRS = nBits / 2;
    // A one-pair word still needs a 1-bit beat counter.
    localparam int BEAT_W = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NPAIRS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [DIV_WIDTH-1:0] div;
    logic               tick;
    logic [nBits-1:0]   shreg;
    logic [BEAT_W-1:0]  beat;

    // Free-running divider; tick is the single cycle where it is all-ones.
    assign tick     = &div;
    assign tick_out = tick;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else begin
            div <= div + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            beat      <= '0;
            pairOut   <= 2'b00;
            pairValid <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            pairCount <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg     <= inData;
                        beat      <= '0;
                        pairCount <= '0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    pairOut   <= shreg[1:0];
                    pairValid <= 1'b1;
                    if (shreg[1:0] == 2'b11) begin
                        pairCount <= pairCount + nOutputBits'(1);
                    end
                    shreg <= shreg >> 2;
                    beat  <= beat + BEAT_W'(1);
                    if (beat == LAST_BEAT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Last pair has had its full tick period; drop the line.
                    pairValid <= 1'b0;
                    pairOut   <= 2'b00;
                    busy      <= 1'b0;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_transmitter.sv
// tb/tb_pair_transmitter.sv - self-checking bench for pair_transmitter

module tb_pair_transmitter;

    localparam int NB = 8;
    localparam int NO = 4;
    localparam int DW = 2;
    localparam int NP = NB / 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [NB-1:0] inData;
    logic [1:0]    pairOut;
    logic          pairValid;
    logic          busy;
    logic          ready;
    logic [NO-1:0] pairCount;
    logic          tick_out;

    int checks = 0;
    int errors = 0;
    logic [NO-1:0] last_count;

    // {pairOut, pairValid, busy, ready, pairCount}
    logic [8:0] obs;
    assign obs = {pairOut, pairValid, busy, ready, pairCount};

    pair_transmitter #(
        .nBits(NB),
        .nOutputBits(NO),
        .DIV_WIDTH(DW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .inData(inData),
        .pairOut(pairOut),
        .pairValid(pairValid),
        .busy(busy),
        .ready(ready),
        .pairCount(pairCount),
        .tick_out(tick_out)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] pair_of(logic [NB-1:0] w, int i);
        return w[2*i +: 2];
    endfunction

    // Number of 2'b11 pairs among the first n pairs of w.
    function automatic int ones_pairs(logic [NB-1:0] w, int n);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            if (pair_of(w, i) == 2'b11) c++;
        end
        return c;
    endfunction

    // Advance to just after the next tick edge.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge clock);
            if (tick_out === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_tick: tick_out stayed 0 for 16 clocks, required a pulse");
        end else begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic accept_tick(input logic [NB-1:0] word);
        logic [8:0] exp;
        start  = 1'b1;
        inData = word;
        wait_tick();
        exp = {2'b00, 1'b0, 1'b1, 1'b0, NO'(0)};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL accept %h: got %b required %b", word, obs, exp);
        end
    endtask

    // mode 0: start low, noise on inData; 1: start high with noise until
    // before the DONE tick; 2: start held high with the same word.
    task automatic send_frame(input logic [NB-1:0] word, input int mode);
        logic [8:0] exp;
        for (int i = 0; i < NP; i++) begin
            case (mode)
                0: begin start = 1'b0; inData = NB'($urandom); end
                1: begin start = 1'b1; inData = NB'($urandom); end
                default: begin start = 1'b1; inData = word; end
            endcase
            wait_tick();
            exp = {pair_of(word, i), 1'b1, 1'b1, 1'b0, NO'(ones_pairs(word, i + 1))};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pair %0d of %h: got %b required %b", i, word, obs, exp);
            end
        end
        if (mode == 1) start = 1'b0;
        wait_tick();
        last_count = NO'(ones_pairs(word, NP));
        exp = {2'b00, 1'b0, 1'b0, 1'b1, last_count};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL done %h: got %b required %b", word, obs, exp);
        end
    endtask

    task automatic expect_idle(input string name);
        logic [8:0] exp;
        exp = {2'b00, 1'b0, 1'b0, 1'b1, last_count};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, obs, exp);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        start  = 1'b0;
        inData = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({obs, tick_out} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b", {obs, tick_out}, 10'b0);
        end
        @(negedge clock);
        reset = 1'b1;
        // k clocks after release the divider holds k mod 4.
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clock);
            checks++;
            if (tick_out !== ((k % 4) == 3)) begin
                errors++;
                $display("FAIL tick_phase %0d: got %b required %b", k, tick_out, ((k % 4) == 3));
            end
        end
    endtask

    task automatic test_basic();
        accept_tick(8'b11011011);
        send_frame(8'b11011011, 0);
    endtask

    task automatic test_two_frames();
        accept_tick(8'hFF);
        send_frame(8'hFF, 0);
        wait_tick();
        expect_idle("idle_between_frames");
        accept_tick(8'h00);
        send_frame(8'h00, 0);
    endtask

    task automatic test_ignore_during_send();
        accept_tick(8'hC3);
        send_frame(8'hC3, 1);
        wait_tick();
        expect_idle("no_frame_after_ignored_start");
    endtask

    task automatic test_start_between_ticks();
        wait_tick();
        start  = 1'b1;
        inData = 8'hFF;
        repeat (2) @(posedge clock);
        #1;
        start = 1'b0;
        wait_tick();
        expect_idle("start_between_ticks");
    endtask

    task automatic test_reset_mid_frame();
        accept_tick(8'hFF);
        start = 1'b0;
        wait_tick();
        wait_tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({obs, tick_out} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: got %b required %b", {obs, tick_out}, 10'b0);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        accept_tick(8'h0C);
        send_frame(8'h0C, 0);
    endtask

    task automatic test_back_to_back();
        accept_tick(8'hF0);
        send_frame(8'hF0, 2);
        accept_tick(8'hF0);
        send_frame(8'hF0, 2);
        accept_tick(8'hF0);
        send_frame(8'hF0, 0);
    endtask

    task automatic test_random();
        logic [NB-1:0] w;
        for (int f = 0; f < 8; f++) begin
            w = NB'($urandom);
            accept_tick(w);
            send_frame(w, int'($urandom_range(0, 1)));
            start = 1'b0;
            wait_tick();
            expect_idle("random_idle");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_frames();
        test_ignore_during_send();
        test_start_between_ticks();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
